// File: rtl/network_ejector.sv
// network_ejector: buffers router flits in per-VC FIFOs and merges them with a
// local loop-back stream into one packet-atomic valid/ready transport stream.
module network_ejector #(
  parameter int unsigned NetworkIfFlitWidth               = 64,
  parameter int unsigned NetworkIfFlitTypeWidth           = 2,
  parameter int unsigned NetworkIfBroadcastWidth          = 1,
  parameter int unsigned NetworkIfVirtualNetworkIdWidth   = 2,
  parameter int unsigned NetworkIfVirtualChannelIdWidth   = 2,
  parameter int unsigned NetworkIfNumberOfVirtualChannels = 3,
  parameter int unsigned NetworkIfBufferDepth             = 4
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        network_valid_i,
  output logic [NetworkIfNumberOfVirtualChannels-1:0] network_avail_o,
  input  logic [NetworkIfFlitWidth-1:0]               network_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_i,
  input  logic [NetworkIfVirtualChannelIdWidth-1:0]   network_virtual_channel_id_i,
  input  logic                                        local_valid_i,
  output logic                                        local_ready_o,
  input  logic [NetworkIfFlitWidth-1:0]               local_flit_i,
  input  logic [NetworkIfFlitTypeWidth-1:0]           local_flit_type_i,
  input  logic [NetworkIfBroadcastWidth-1:0]          local_broadcast_i,
  input  logic [NetworkIfVirtualNetworkIdWidth-1:0]   local_virtual_network_id_i,
  output logic                                        tlp_valid_o,
  input  logic                                        tlp_ready_i,
  output logic [NetworkIfFlitWidth-1:0]               tlp_flit_o,
  output logic [NetworkIfFlitTypeWidth-1:0]           tlp_flit_type_o,
  output logic [NetworkIfBroadcastWidth-1:0]          tlp_broadcast_o,
  output logic [NetworkIfVirtualChannelIdWidth-1:0]   tlp_virtual_channel_id_o,
  output logic                                        protocol_error_o
);

  localparam int unsigned FW     = NetworkIfFlitWidth;
  localparam int unsigned TW     = NetworkIfFlitTypeWidth;
  localparam int unsigned BW     = NetworkIfBroadcastWidth;
  localparam int unsigned VcW    = NetworkIfVirtualChannelIdWidth;
  localparam int unsigned NumVc  = NetworkIfNumberOfVirtualChannels;
  localparam int unsigned Depth  = NetworkIfBufferDepth;
  localparam int unsigned NumSrc = NumVc + 1;
  localparam int unsigned SrcW   = (NumSrc > 1) ? $clog2(NumSrc) : 1;
  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CntW   = AddrW + 1;

  localparam logic [SrcW-1:0] LocalSrc = SrcW'(NumVc);

  localparam logic [TW-1:0] FlitHeader     = TW'(0);
  localparam logic [TW-1:0] FlitBody       = TW'(1);
  localparam logic [TW-1:0] FlitTail       = TW'(2);
  localparam logic [TW-1:0] FlitHeaderTail = TW'(3);

  typedef enum logic {ArbUnlocked, ArbLocked} arb_state_e;

  function automatic logic is_header(input logic [TW-1:0] t);
    return (t == FlitHeader) || (t == FlitHeaderTail);
  endfunction

  // Per-VC ejection FIFOs
  logic [FW-1:0]    buf_flit_q [NumVc][Depth];
  logic [TW-1:0]    buf_type_q [NumVc][Depth];
  logic [BW-1:0]    buf_bc_q   [NumVc][Depth];
  logic [AddrW-1:0] wr_ptr_q   [NumVc];
  logic [AddrW-1:0] rd_ptr_q   [NumVc];
  logic [CntW-1:0]  count_q    [NumVc];
  logic [CntW-1:0]  count_d    [NumVc];
  logic [NumVc-1:0] avail_q, avail_d;
  logic [NumVc-1:0] wr_en, rd_en;
  logic             bad_ingress;

  // Unified view of all sources, LOCAL being the last index
  logic [NumSrc-1:0] src_req;
  logic [FW-1:0]     src_flit [NumSrc];
  logic [TW-1:0]     src_type [NumSrc];
  logic [BW-1:0]     src_bc   [NumSrc];
  logic [VcW-1:0]    src_vc   [NumSrc];

  arb_state_e        state_q, state_d;
  logic [SrcW-1:0]   lock_src_q, lock_src_d;
  logic [SrcW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SrcW-1:0]   hold_src_q, hold_src_d;
  logic              hold_q, hold_d;
  logic              err_q, err_d;
  logic [SrcW-1:0]   grant_src;
  logic              grant_valid;
  logic [TW-1:0]     grant_type;
  logic              xfer;
  logic              found;
  logic              lock_err;
  logic [NumSrc-1:0] drop;
  int unsigned       cand;

  always_comb begin
    wr_en       = '0;
    bad_ingress = 1'b0;
    found       = 1'b0;
    if (network_valid_i) begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        if (network_virtual_channel_id_i == VcW'(v)) begin
          found = 1'b1;
          if (avail_q[v]) wr_en[v] = 1'b1;
          else            bad_ingress = 1'b1;
        end
      end
      if (!found) bad_ingress = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned v = 0; v < NumVc; v++) begin
      if (wr_en[v]) begin
        buf_flit_q[v][wr_ptr_q[v]] <= network_flit_i;
        buf_type_q[v][wr_ptr_q[v]] <= network_flit_type_i;
        buf_bc_q[v][wr_ptr_q[v]]   <= network_broadcast_i;
      end
    end
  end

  always_comb begin
    avail_d = '0;
    for (int unsigned v = 0; v < NumVc; v++) begin
      count_d[v] = count_q[v];
      if (wr_en[v] && !rd_en[v])      count_d[v] = count_q[v] + CntW'(1);
      else if (!wr_en[v] && rd_en[v]) count_d[v] = count_q[v] - CntW'(1);
      avail_d[v] = (count_d[v] < CntW'(Depth));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        count_q[v]  <= '0;
      end
      avail_q <= '1;
    end else begin
      for (int unsigned v = 0; v < NumVc; v++) begin
        if (wr_en[v]) wr_ptr_q[v] <= wr_ptr_q[v] + AddrW'(1);
        if (rd_en[v]) rd_ptr_q[v] <= rd_ptr_q[v] + AddrW'(1);
        count_q[v] <= count_d[v];
      end
      avail_q <= avail_d;
    end
  end

  always_comb begin
    src_req = '0;
    for (int unsigned v = 0; v < NumVc; v++) begin
      src_req[v]  = (count_q[v] != '0);
      src_flit[v] = buf_flit_q[v][rd_ptr_q[v]];
      src_type[v] = buf_type_q[v][rd_ptr_q[v]];
      src_bc[v]   = buf_bc_q[v][rd_ptr_q[v]];
      src_vc[v]   = VcW'(v);
    end
    src_req[NumVc]  = local_valid_i;
    src_flit[NumVc] = local_flit_i;
    src_type[NumVc] = local_flit_type_i;
    src_bc[NumVc]   = local_broadcast_i;
    src_vc[NumVc]   = VcW'(local_virtual_network_id_i);
  end

  always_comb begin
    state_d     = state_q;
    lock_src_d  = lock_src_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = 1'b0;
    hold_src_d  = hold_src_q;
    grant_src   = '0;
    grant_valid = 1'b0;
    drop        = '0;
    lock_err    = 1'b0;
    cand        = 0;

    if (state_q == ArbLocked) begin
      grant_src   = lock_src_q;
      grant_valid = src_req[lock_src_q];
    end else if (hold_q) begin
      // A stalled grant is pinned so the presented flit cannot change under backpressure.
      grant_src   = hold_src_q;
      grant_valid = src_req[hold_src_q];
    end else begin
      for (int unsigned i = 0; i < NumSrc; i++) begin
        cand = 32'(rr_ptr_q) + i;
        if (cand >= NumSrc) cand = cand - NumSrc;
        if (!grant_valid && src_req[cand] && is_header(src_type[cand])) begin
          grant_valid = 1'b1;
          grant_src   = SrcW'(cand);
        end
      end
    end

    if (state_q == ArbUnlocked) begin
      for (int unsigned s = 0; s < NumSrc; s++) begin
        drop[s] = src_req[s] && !is_header(src_type[s]);
      end
    end

    grant_valid = grant_valid & ~rst_i;
    grant_type  = src_type[grant_src];
    xfer        = grant_valid & tlp_ready_i;

    if (state_q == ArbUnlocked) begin
      hold_d     = grant_valid & ~tlp_ready_i;
      hold_src_d = grant_src;
      if (xfer) begin
        rr_ptr_d = (grant_src == SrcW'(NumSrc - 1)) ? '0 : grant_src + SrcW'(1);
        if (grant_type == FlitHeader) begin
          state_d    = ArbLocked;
          lock_src_d = grant_src;
        end
      end
    end else if (xfer) begin
      if (grant_type == FlitTail || grant_type == FlitHeaderTail) state_d = ArbUnlocked;
      lock_err = is_header(grant_type);
    end

    err_d = err_q | bad_ingress | (|drop) | lock_err;
  end

  always_comb begin
    rd_en = '0;
    for (int unsigned v = 0; v < NumVc; v++) begin
      rd_en[v] = drop[v] | (xfer & (grant_src == SrcW'(v)));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbUnlocked;
      lock_src_q <= '0;
      rr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      hold_src_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_q     <= hold_d;
      hold_src_q <= hold_src_d;
      err_q      <= err_d;
    end
  end

  assign network_avail_o          = avail_q;
  assign tlp_valid_o              = grant_valid;
  assign tlp_flit_o               = src_flit[grant_src];
  assign tlp_flit_type_o          = grant_type;
  assign tlp_broadcast_o          = src_bc[grant_src];
  assign tlp_virtual_channel_id_o = src_vc[grant_src];
  // A misplaced local body/tail is consumed (dropped) just like a FIFO head.
  assign local_ready_o            = ~rst_i & (((grant_src == LocalSrc) & tlp_ready_i) | drop[NumVc]);
  assign protocol_error_o         = err_q;

  logic unused_body_enc;
  assign unused_body_enc = ^FlitBody;

endmodule

// File: tb/tb_network_ejector.sv
// Self-checking bench for network_ejector: directed scenarios plus random
// packet traffic, all compared against a queue-based transaction model.
module tb_network_ejector;

  localparam logic [1:0] T_H  = 2'd0;
  localparam logic [1:0] T_B  = 2'd1;
  localparam logic [1:0] T_T  = 2'd2;
  localparam logic [1:0] T_HT = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic        n_valid;
  logic [2:0]  n_avail;
  logic [63:0] n_flit;
  logic [1:0]  n_type;
  logic        n_bc;
  logic [1:0]  n_vc;
  logic        l_valid, l_ready;
  logic [63:0] l_flit;
  logic [1:0]  l_type;
  logic        l_bc;
  logic [1:0]  l_vn;
  logic        t_valid, t_ready;
  logic [63:0] t_flit;
  logic [1:0]  t_type;
  logic        t_bc;
  logic [1:0]  t_vc;
  logic        perr;

  always #5 clk = ~clk;

  network_ejector #(
    .NetworkIfFlitWidth(64),
    .NetworkIfFlitTypeWidth(2),
    .NetworkIfBroadcastWidth(1),
    .NetworkIfVirtualNetworkIdWidth(2),
    .NetworkIfVirtualChannelIdWidth(2),
    .NetworkIfNumberOfVirtualChannels(3),
    .NetworkIfBufferDepth(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .network_valid_i(n_valid),
    .network_avail_o(n_avail),
    .network_flit_i(n_flit),
    .network_flit_type_i(n_type),
    .network_broadcast_i(n_bc),
    .network_virtual_channel_id_i(n_vc),
    .local_valid_i(l_valid),
    .local_ready_o(l_ready),
    .local_flit_i(l_flit),
    .local_flit_type_i(l_type),
    .local_broadcast_i(l_bc),
    .local_virtual_network_id_i(l_vn),
    .tlp_valid_o(t_valid),
    .tlp_ready_i(t_ready),
    .tlp_flit_o(t_flit),
    .tlp_flit_type_o(t_type),
    .tlp_broadcast_o(t_bc),
    .tlp_virtual_channel_id_o(t_vc),
    .protocol_error_o(perr)
  );

  typedef struct packed {
    logic [63:0] flit;
    logic [1:0]  ftype;
    logic        bc;
  } flit_t;

  // Reference model: one queue per VC, a lock owner (-1 = none), rr pointer
  flit_t mq [3][$];
  int    m_lock, m_ptr, m_hold;
  bit    m_err;
  bit [2:0] m_avail;

  int    e_src;
  bit    e_valid, e_lready, l_taken;
  bit [3:0] e_drop;
  flit_t e_head;

  bit          s_valid, s_lready, s_err;
  bit [2:0]    s_avail;
  logic [63:0] s_flit;
  logic [1:0]  s_vc;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit hdr(input logic [1:0] t);
    return (t == T_H) || (t == T_HT);
  endfunction

  function automatic bit m_req(input int s);
    if (s < 3) return mq[s].size() != 0;
    return l_valid === 1'b1;
  endfunction

  function automatic flit_t m_head(input int s);
    if (s < 3) return mq[s][0];
    return {l_flit, l_type, l_bc};
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 3; v++) mq[v].delete();
    m_lock = -1; m_ptr = 0; m_hold = -1; m_err = 0; m_avail = 3'b111;
  endtask

  task automatic model_eval();
    flit_t h;
    e_src = -1; e_valid = 0; e_drop = '0;
    if (m_lock >= 0) begin
      e_src = m_lock; e_valid = m_req(m_lock);
    end else if (m_hold >= 0) begin
      e_src = m_hold; e_valid = m_req(m_hold);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (e_src < 0 && m_req((m_ptr + k) % 4)) begin
          h = m_head((m_ptr + k) % 4);
          if (hdr(h.ftype)) begin e_src = (m_ptr + k) % 4; e_valid = 1; end
        end
      end
    end
    if (m_lock < 0) begin
      for (int s = 0; s < 4; s++) begin
        if (m_req(s)) begin
          h = m_head(s);
          if (!hdr(h.ftype)) e_drop[s] = 1'b1;
        end
      end
    end
    e_lready = (e_src == 3 && t_ready) || e_drop[3];
    if (e_valid) e_head = m_head(e_src);
  endtask

  task automatic compare();
    check_eq("tlp_valid", t_valid, e_valid);
    if (e_valid) begin
      check_eq("tlp_flit", t_flit, e_head.flit);
      check_eq("tlp_type", t_type, e_head.ftype);
      check_eq("tlp_bc", t_bc, e_head.bc);
      if (e_src < 3) check_eq("tlp_vc", t_vc, e_src);
      else           check_eq("tlp_vc", t_vc, l_vn);
    end
    check_eq("local_ready", l_ready, e_lready);
    check_eq("net_avail", n_avail, m_avail);
    check_eq("proto_err", perr, m_err);
    s_valid = t_valid; s_lready = l_ready; s_err = perr;
    s_avail = n_avail; s_flit = t_flit; s_vc = t_vc;
  endtask

  task automatic commit();
    bit xfer;
    xfer = e_valid && t_ready;
    for (int s = 0; s < 3; s++)
      if (e_drop[s] || (xfer && e_src == s)) void'(mq[s].pop_front());
    l_taken = e_lready && l_valid;
    if (|e_drop) m_err = 1;
    if (n_valid) begin
      if (n_vc < 2'd3 && m_avail[n_vc]) mq[n_vc].push_back({n_flit, n_type, n_bc});
      else m_err = 1;
    end
    if (m_lock < 0) begin
      m_hold = (e_valid && !t_ready) ? e_src : -1;
      if (xfer) begin
        m_ptr = (e_src + 1) % 4;
        if (e_head.ftype == T_H) m_lock = e_src;
      end
    end else if (xfer) begin
      if (e_head.ftype == T_T || e_head.ftype == T_HT) m_lock = -1;
      if (hdr(e_head.ftype)) m_err = 1;
    end
    for (int v = 0; v < 3; v++) m_avail[v] = mq[v].size() < 4;
  endtask

  task automatic step();
    @(negedge clk);
    model_eval();
    compare();
    commit();
    @(posedge clk);
    #1;
    if (l_taken) l_valid = 1'b0;
  endtask

  task automatic idle();
    n_valid = 0; n_flit = '0; n_type = T_H; n_bc = 0; n_vc = 0;
  endtask

  task automatic send(input int vc, input logic [1:0] ty, input logic [63:0] f);
    n_valid = 1; n_vc = 2'(vc); n_type = ty; n_flit = f; n_bc = 1'($urandom_range(0, 1));
  endtask

  task automatic next_type(inout int rem, output logic [1:0] ty);
    int len;
    if (rem == 0) begin
      len = $urandom_range(1, 3);
      ty  = (len == 1) ? T_HT : T_H;
      rem = len - 1;
    end else begin
      rem--;
      ty = (rem == 0) ? T_T : T_B;
    end
  endtask

  logic [63:0] f;
  int          vcq[$];
  int          lrq[$];
  int          vc_rem[3];
  int          l_rem;
  int          rv;
  logic [1:0]  ty;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    t_ready = 1; l_flit = '0; l_bc = 0; l_vn = 0; l_type = T_HT; l_valid = 1;
    rst = 1;
    model_reset();
    #12;
    check_eq("rst_tlp_valid", t_valid, 0);
    check_eq("rst_local_ready", l_ready, 0);
    check_eq("rst_avail", n_avail, 3'b111);
    check_eq("rst_err", perr, 0);
    l_valid = 0;
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Single header_tail on VC1
    f = rnd64(); f[63:53] = 11'h005;
    send(1, T_HT, f); step();
    idle(); step();
    check_eq("t1_valid", s_valid, 1);
    check_eq("t1_flit", s_flit, f);
    check_eq("t1_vc", s_vc, 1);
    check_eq("t1_avail", s_avail, 3'b111);

    // Fill VC0 under backpressure, then release a single beat
    t_ready = 0;
    send(0, T_H, rnd64()); step();
    send(0, T_B, rnd64()); step();
    send(0, T_B, rnd64()); step();
    send(0, T_T, rnd64()); step();
    idle(); step();
    check_eq("t2_full", s_avail[0], 0);
    t_ready = 1; step();
    t_ready = 0; step();
    check_eq("t2_reopen", s_avail[0], 1);
    t_ready = 1;
    repeat (5) step();

    // Interleaved packets on VC0 and VC2 leave contiguously
    vcq.delete();
    send(0, T_H, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    send(2, T_H, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    send(0, T_B, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    send(2, T_B, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    send(0, T_T, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    send(2, T_T, rnd64()); step(); if (s_valid) vcq.push_back(s_vc);
    idle();
    repeat (6) begin step(); if (s_valid) vcq.push_back(s_vc); end
    check_eq("t3_count", vcq.size(), 6);
    for (int i = 0; i < vcq.size() && i < 6; i++) check_eq("t3_order", vcq[i], (i < 3) ? 0 : 2);

    // Park the pointer at VC0, then LOCAL and VC0 contend
    l_valid = 1; l_type = T_HT; l_vn = 1; l_flit = rnd64(); step();
    t_ready = 0;
    repeat (4) begin send(0, T_HT, rnd64()); step(); end
    idle();
    l_valid = 1; l_type = T_HT; l_vn = 1; l_flit = rnd64();
    t_ready = 1;
    vcq.delete(); lrq.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      vcq.push_back(s_vc); lrq.push_back(s_lready);
      if (!l_valid && i < 3) begin l_valid = 1; l_flit = rnd64(); end
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_local_ready", lrq[i], i % 2);
      check_eq("t4_src_vc", vcq[i], i % 2);
    end
    l_valid = 0;
    repeat (6) step();

    // Write on VC1 while it advertises no space
    t_ready = 0;
    repeat (4) begin send(1, T_HT, rnd64()); step(); end
    idle(); step();
    check_eq("t5_avail1_low", s_avail[1], 0);
    send(1, T_HT, rnd64()); step();
    idle(); step();
    check_eq("t5_err", s_err, 1);
    t_ready = 1;
    repeat (8) step();
    check_eq("t5_err_held", s_err, 1);

    // Reset in the middle of a locked VC0 packet
    send(0, T_H, rnd64()); step();
    send(0, T_B, rnd64()); step();
    t_ready = 0;
    send(0, T_B, rnd64()); step();
    idle();
    #2 rst = 1;
    #1;
    check_eq("t6_valid", t_valid, 0);
    check_eq("t6_avail", n_avail, 3'b111);
    check_eq("t6_err_clr", perr, 0);
    model_reset();
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    t_ready = 1;
    send(2, T_H, rnd64()); step();
    idle(); step();
    check_eq("t6_fresh_valid", s_valid, 1);
    check_eq("t6_fresh_vc", s_vc, 2);
    send(2, T_T, rnd64()); step();
    idle(); repeat (2) step();

    // Random well-formed traffic from all VCs and LOCAL
    for (int v = 0; v < 3; v++) vc_rem[v] = 0;
    l_rem = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      t_ready = ($urandom_range(0, 9) < 7);
      idle();
      if ($urandom_range(0, 1) == 1) begin
        rv = $urandom_range(0, 2);
        if (m_avail[rv]) begin
          next_type(vc_rem[rv], ty);
          send(rv, ty, rnd64());
        end
      end
      if (!l_valid && $urandom_range(0, 2) == 0) begin
        if (l_rem == 0) l_vn = 2'($urandom_range(0, 2));
        next_type(l_rem, ty);
        l_type = ty; l_flit = rnd64(); l_bc = 1'($urandom_range(0, 1));
        l_valid = 1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
